// File: rtl/mux_arb_pkg.sv
// Shared types and the rotating-priority pick used by the 4-way round-robin arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } arb_pick_t;

  // First requester at or after ptr, wrapping 3->0. Scanning from the far end
  // lets the closest hit overwrite, so the lowest offset from ptr wins.
  function automatic arb_pick_t arb_pick(input logic [N_REQ-1:0] req,
                                         input logic [1:0]       ptr);
    arb_pick_t  r;
    logic [1:0] i;
    r = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      i = ptr + 2'(k);
      if (req[i]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4_1.sv
// Plain 4:1 data mux driven by the arbiter select.
module mux4_1 #(
  parameter int W = 16
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   s,
  output logic [W-1:0] y
);

  always_comb begin
    case (s)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter: one shared BUS_WIDTH channel, 4 requesters, valid/ready out.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [BUS_WIDTH-1:0] d0,
  input  logic [BUS_WIDTH-1:0] d1,
  input  logic [BUS_WIDTH-1:0] d2,
  input  logic [BUS_WIDTH-1:0] d3,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     gnt,
  output logic [1:0]           sel
);

  localparam int             CW   = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0]  LAST = CW'(BURST_MAX - 1);

  arb_state_t    state;
  logic [1:0]    gnt_idx;
  logic [1:0]    ptr;
  logic [CW-1:0] beat_cnt;

  arb_pick_t     pick_idle;
  arb_pick_t     pick_rel;
  logic          xfer;
  logic          rel;

  always_comb begin
    pick_idle = arb_pick(req, ptr);
    // Re-arbitration on release starts just past the current owner so it ranks last.
    pick_rel  = arb_pick(req, gnt_idx + 2'd1);
    out_valid = 1'b0;
    gnt       = '0;
    sel       = 2'd0;
    ack       = '0;
    xfer      = 1'b0;
    rel       = 1'b0;
    if (state == ARB_BUSY) begin
      sel       = gnt_idx;
      gnt       = N_REQ'(1) << gnt_idx;
      out_valid = req[gnt_idx];
      xfer      = out_valid & out_ready;
      ack       = xfer ? (N_REQ'(1) << gnt_idx) : '0;
      rel       = (xfer && beat_cnt == LAST) || !req[gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      gnt_idx  <= 2'd0;
      ptr      <= 2'd0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_idle.found) begin
            state    <= ARB_BUSY;
            gnt_idx  <= pick_idle.idx;
            beat_cnt <= '0;
          end
        end
        default: begin
          if (rel) begin
            ptr      <= gnt_idx + 2'd1;
            beat_cnt <= '0;
            if (pick_rel.found) gnt_idx <= pick_rel.idx;
            else                state   <= ARB_IDLE;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  mux4_1 #(.W(BUS_WIDTH)) u_mux (
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .s  (sel),
    .y  (out_data)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: BURST_MAX=4 and BURST_MAX=1 instances share one stimulus bus.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] d0, d1, d2, d3;
  logic        out_ready;

  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic [3:0]  a_ack, b_ack, a_gnt, b_gnt;
  logic [1:0]  a_sel, b_sel;

  int checks = 0;
  int passed = 0;

  logic [1:0]  exp_idx[$];
  logic [15:0] exp_data[$];

  mux4_rr_arbiter #(.BUS_WIDTH(16), .BURST_MAX(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_ready(out_ready), .out_data(a_data), .out_valid(a_valid),
    .ack(a_ack), .gnt(a_gnt), .sel(a_sel)
  );

  mux4_rr_arbiter #(.BUS_WIDTH(16), .BURST_MAX(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_ready(out_ready), .out_data(b_data), .out_valid(b_valid),
    .ack(b_ack), .gnt(b_gnt), .sel(b_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // Leaves the bench just after a falling edge with everything idle.
  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    out_ready = 1'b1;
    exp_idx.delete();
    exp_data.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b1;
    d0 = 16'h1234; d1 = 16'h1111; d2 = 16'h2222; d3 = 16'h3333;
    @(negedge clk);
    checks++; if (a_gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", a_gnt); else passed++;
    checks++; if (a_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", a_valid); else passed++;
    checks++; if (a_ack !== 4'b0000) $display("FAIL reset_ack got=%b exp=0000", a_ack); else passed++;
    checks++; if (a_sel !== 2'd0) $display("FAIL reset_sel got=%0d exp=0", a_sel); else passed++;
    checks++; if (a_data !== 16'h1234) $display("FAIL reset_data got=%h exp=1234", a_data); else passed++;
    checks++; if (b_gnt !== 4'b0000) $display("FAIL reset_gnt_b1 got=%b exp=0000", b_gnt); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    d0 = 16'hC0DE;
    req = 4'b0001;
    #1;
    checks++; if (a_gnt !== 4'b0000) $display("FAIL single_latency got=%b exp=0000", a_gnt); else passed++;
    for (int i = 0; i < 10; i++) begin exp_idx.push_back(2'd0); exp_data.push_back(16'hC0DE); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (a_gnt !== 4'b0001 || a_ack !== 4'b0001 || exp_idx.size() == 0)
        $display("FAIL single_beat%0d gnt=%b ack=%b exp gnt=0001 ack=0001", c, a_gnt, a_ack);
      else begin
        if (oh2idx(a_ack) !== exp_idx[0] || a_data !== exp_data[0])
          $display("FAIL single_sb%0d got idx=%0d data=%h exp idx=%0d data=%h",
                   c, oh2idx(a_ack), a_data, exp_idx[0], exp_data[0]);
        else passed++;
        void'(exp_idx.pop_front()); void'(exp_data.pop_front());
      end
    end
    checks++; if (exp_idx.size() != 0) $display("FAIL single_left got=%0d exp=0", exp_idx.size()); else passed++;
  endtask

  task automatic test_burst1_rotation();
    apply_reset();
    d0 = 16'h0A00; d1 = 16'h0A01; d2 = 16'h0A02; d3 = 16'h0A03;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_idx.push_back(2'(i % 4));
      exp_data.push_back(16'h0A00 + 16'(i % 4));
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (b_ack === 4'b0000 || exp_idx.size() == 0)
        $display("FAIL rot_bubble%0d got ack=%b exp one-hot", c, b_ack);
      else begin
        if (oh2idx(b_ack) !== exp_idx[0] || b_data !== exp_data[0])
          $display("FAIL rot_order%0d got idx=%0d data=%h exp idx=%0d data=%h",
                   c, oh2idx(b_ack), b_data, exp_idx[0], exp_data[0]);
        else passed++;
        void'(exp_idx.pop_front()); void'(exp_data.pop_front());
      end
    end
    checks++; if (exp_idx.size() != 0) $display("FAIL rot_left got=%0d exp=0", exp_idx.size()); else passed++;
  endtask

  task automatic test_burst4_pair();
    apply_reset();
    d0 = 16'hAAAA; d2 = 16'h5555;
    req = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      exp_idx.push_back((i / 4) % 2 == 0 ? 2'd0 : 2'd2);
      exp_data.push_back((i / 4) % 2 == 0 ? 16'hAAAA : 16'h5555);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (a_ack === 4'b0000 || exp_idx.size() == 0)
        $display("FAIL pair_bubble%0d got ack=%b exp one-hot", c, a_ack);
      else begin
        if (oh2idx(a_ack) !== exp_idx[0] || a_data !== exp_data[0])
          $display("FAIL pair_beat%0d got idx=%0d data=%h exp idx=%0d data=%h",
                   c, oh2idx(a_ack), a_data, exp_idx[0], exp_data[0]);
        else passed++;
        void'(exp_idx.pop_front()); void'(exp_data.pop_front());
      end
    end
    checks++; if (exp_idx.size() != 0) $display("FAIL pair_left got=%0d exp=0", exp_idx.size()); else passed++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    d1 = 16'hBEEF;
    req = 4'b0010;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (a_valid !== 1'b1 || a_data !== 16'hBEEF || a_ack !== 4'b0000 || a_gnt !== 4'b0010)
        $display("FAIL stall%0d got v=%b d=%h ack=%b gnt=%b exp v=1 d=beef ack=0000 gnt=0010",
                 c, a_valid, a_data, a_ack, a_gnt);
      else passed++;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (a_ack !== 4'b0010) $display("FAIL stall_release got ack=%b exp=0010", a_ack); else passed++;
  endtask

  task automatic test_drop_midburst();
    apply_reset();
    d0 = 16'h0D00; d3 = 16'h0D33;
    req = 4'b1000;
    @(negedge clk);
    checks++; if (a_ack !== 4'b1000) $display("FAIL drop_beat1 got ack=%b exp=1000", a_ack); else passed++;
    req = 4'b1001;
    @(negedge clk);
    checks++; if (a_ack !== 4'b1000) $display("FAIL drop_beat2 got ack=%b exp=1000", a_ack); else passed++;
    req = 4'b0001;
    #1;
    checks++;
    if (a_ack !== 4'b0000 || a_gnt !== 4'b1000)
      $display("FAIL drop_noack got ack=%b gnt=%b exp ack=0000 gnt=1000", a_ack, a_gnt);
    else passed++;
    @(negedge clk);
    checks++;
    if (a_gnt !== 4'b0001 || a_ack !== 4'b0001 || a_data !== 16'h0D00)
      $display("FAIL drop_handover got gnt=%b ack=%b d=%h exp gnt=0001 ack=0001 d=0d00",
               a_gnt, a_ack, a_data);
    else passed++;
  endtask

  task automatic test_reset_midburst();
    apply_reset();
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_gnt !== 4'b0000 || a_valid !== 1'b0 || a_ack !== 4'b0000)
      $display("FAIL async_reset got gnt=%b v=%b ack=%b exp 0000/0/0000", a_gnt, a_valid, a_ack);
    else passed++;
    checks++; if (b_gnt !== 4'b0000) $display("FAIL async_reset_b1 got gnt=%b exp=0000", b_gnt); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (a_gnt !== 4'b0000) $display("FAIL post_reset_idle got gnt=%b exp=0000", a_gnt); else passed++;
    @(negedge clk);
    checks++; if (a_gnt !== 4'b0001) $display("FAIL post_reset_first got gnt=%b exp=0001", a_gnt); else passed++;
    checks++; if (b_gnt !== 4'b0001) $display("FAIL post_reset_first_b1 got gnt=%b exp=0001", b_gnt); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b1;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    test_reset();
    test_single();
    test_burst1_rotation();
    test_burst4_pair();
    test_backpressure();
    test_drop_midburst();
    test_reset_midburst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
